// File: rtl/mips_shift_unit.sv
// mips_shift_unit: multi-cycle SLL/SRL/SRA/ROTR shifter, at most STEP bits per cycle,
// with a start/in_ready and out_valid handshake.
module mips_shift_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   inData,
   output logic               in_ready,
   output logic               busy,
   output logic               out_valid,
   output logic [WIDTH-1:0]   outData
);
   localparam int KW = SHAMT_W + 1;

   if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0 || (1 << SHAMT_W) != WIDTH ||
       STEP < 1 || STEP > WIDTH || (STEP & (STEP - 1)) != 0) begin : gBadParams
      $error("mips_shift_unit: illegal WIDTH/SHAMT_W/STEP combination");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, nextState;

   logic [WIDTH-1:0]   acc, shifted, fill;
   logic [SHAMT_W-1:0] rem, remNext;
   logic [1:0]         op;
   logic               sign;
   logic [KW-1:0]      k;

   // k is one bit wider than rem so STEP == WIDTH stays representable
   always_comb begin
      k       = ({1'b0, rem} > KW'(STEP)) ? KW'(STEP) : {1'b0, rem};
      remNext = rem - k[SHAMT_W-1:0];
      fill    = sign ? ~({WIDTH{1'b1}} >> k) : '0;
      shifted = (op == 2'b00) ? acc << k :
                (op == 2'b01) ? acc >> k :
                (op == 2'b10) ? (acc >> k) | fill :
                                (acc >> k) | (acc << (KW'(WIDTH) - k));
   end

   always_comb begin
      nextState = (state == IDLE)  ? (start ? ((shamt == '0) ? DONE : SHIFT) : IDLE) :
                  (state == SHIFT) ? ((remNext == '0) ? DONE : SHIFT) : IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc     <= '0;
         rem     <= '0;
         op      <= '0;
         sign    <= 1'b0;
         outData <= '0;
      end else if (state == IDLE && start) begin
         acc  <= inData;
         rem  <= shamt;
         op   <= mode;
         sign <= inData[WIDTH-1];
         if (shamt == '0) outData <= inData;
      end else if (state == SHIFT) begin
         acc <= shifted;
         rem <= remNext;
         if (remNext == '0) outData <= shifted;
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == SHIFT) || (state == DONE);
   assign out_valid = (state == DONE);
endmodule

// File: tb/tb_mips_shift_unit.sv
// tb_mips_shift_unit: directed and reference-checked stimulus for mips_shift_unit
// (WIDTH=32, STEP=4).
module tb_mips_shift_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [4:0]  shamt = '0;
   logic [31:0] inData = '0;
   logic        in_ready, busy, out_valid;
   logic [31:0] outData;

   int nChecks = 0;
   int nFails  = 0;

   mips_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .shamt(shamt),
      .inData(inData), .in_ready(in_ready), .busy(busy), .out_valid(out_valid),
      .outData(outData)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] refShift(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d);
      logic [31:0] r;
      case (m)
         2'b00:   r = d << s;
         2'b01:   r = d >> s;
         2'b10:   r = $signed(d) >>> s;
         default: r = (d >> s) | (d << (6'd32 - {1'b0, s}));
      endcase
      return r;
   endfunction

   // Issues one op from IDLE; returns edges from accept to out_valid, and the result.
   task automatic runOp(input logic [1:0] m, input logic [4:0] s, input logic [31:0] d,
                        output int lat, output logic [31:0] res);
      logic [31:0] prev;
      @(negedge clk);
      checkVal("ready_before_start", {31'b0, in_ready}, 32'd1);
      prev = outData;
      mode = m; shamt = s; inData = d; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; inData = ~d; shamt = ~s;
      lat = 0;
      res = 'x;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            res = outData;
            break;
         end
         checkVal("hold_during_shift", outData, prev);
         checkVal("busy_during_shift", {30'b0, in_ready, busy}, 32'd1);
      end
      if (lat == 0) checkVal("out_valid_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [31:0] res;
      int seen;
      logic [1:0]  m;
      logic [4:0]  s;
      logic [31:0] d;

      // reset state
      repeat (2) @(negedge clk);
      checkVal("rst_outData", outData, 32'd0);
      checkVal("rst_flags", {29'b0, in_ready, busy, out_valid}, 32'b100);
      reset = 1'b0;

      runOp(2'b00, 5'd2, 32'd70, lat, res);
      checkVal("sll70_res", res, 32'h0000_0118);
      checkVal("sll70_lat", lat, 32'd2);
      @(negedge clk);
      checkVal("sll70_pulse_end", {29'b0, in_ready, busy, out_valid}, 32'b100);

      runOp(2'b10, 5'd31, 32'h8000_0000, lat, res);
      checkVal("sra31_res", res, 32'hFFFF_FFFF);
      checkVal("sra31_lat", lat, 32'd9);

      runOp(2'b01, 5'd31, 32'h8000_0000, lat, res);
      checkVal("srl31_res", res, 32'h0000_0001);
      checkVal("srl31_lat", lat, 32'd9);

      runOp(2'b11, 5'd4, 32'h0000_0001, lat, res);
      checkVal("rotr4_res", res, 32'h1000_0000);
      checkVal("rotr4_lat", lat, 32'd2);

      runOp(2'b11, 5'd5, 32'h0000_0013, lat, res);
      checkVal("rotr5_res", res, 32'h9800_0000);

      // shamt=0 with start held high through the busy cycles
      @(negedge clk);
      mode = 2'b00; shamt = 5'd0; inData = 32'h1234_5678; start = 1'b1;
      @(posedge clk);
      #1 inData = 32'hFFFF_FFFF; shamt = 5'd3;
      @(negedge clk);
      checkVal("sh0_valid", {31'b0, out_valid}, 32'd1);
      checkVal("sh0_res", outData, 32'h1234_5678);
      @(negedge clk);
      checkVal("sh0_ignored_flags", {29'b0, in_ready, busy, out_valid}, 32'b100);
      checkVal("sh0_ignored_data", outData, 32'h1234_5678);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checkVal("next_busy", {29'b0, in_ready, busy, out_valid}, 32'b010);
      checkVal("next_hold", outData, 32'h1234_5678);
      @(negedge clk);
      checkVal("next_valid", {31'b0, out_valid}, 32'd1);
      checkVal("next_res", outData, 32'hFFFF_FFF8);

      // reset mid-SHIFT
      @(negedge clk);
      mode = 2'b10; shamt = 5'd20; inData = 32'h8000_0001; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkVal("abort_outData", outData, 32'd0);
      checkVal("abort_flags", {29'b0, in_ready, busy, out_valid}, 32'b100);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checkVal("abort_no_valid", seen, 32'd0);
      runOp(2'b00, 5'd1, 32'd1, lat, res);
      checkVal("after_abort_res", res, 32'h0000_0002);
      checkVal("after_abort_lat", lat, 32'd2);

      // boundary amounts over every mode, then random operands against the reference
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            m = 2'(i);
            s = (j == 0) ? 5'd1 : (j == 1) ? 5'd4 : (j == 2) ? 5'd5 : 5'd31;
            d = 32'hA5C3_0F96;
            runOp(m, s, d, lat, res);
            checkVal("edge_res", res, refShift(m, s, d));
            checkVal("edge_lat", lat, (32'(s) + 3) / 4 + 1);
         end
      end
      for (int i = 0; i < 300; i++) begin
         m = 2'($urandom_range(0, 3));
         s = 5'($urandom_range(0, 31));
         d = $urandom;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         runOp(m, s, d, lat, res);
         checkVal("rand_res", res, refShift(m, s, d));
         checkVal("rand_lat", lat, (32'(s) + 3) / 4 + 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
